ahb_prior_aging: RTL and testbench

Per-slave priority configurator for a dynamic-priority AHB slave arbiter, placed in front of that arbiter's `hprior` input. It tracks how long each requesting master has waited without a grant and raises that master's priority level one step per `AGE_THRESH` stalled cycles, saturating at the top level. It restores the master's base level once its transaction completes. This prevents starvation of low-priority masters under the fixed-mask arbitration scheme.

---
 rtl/ahb_prior_aging_if.sv | 28 ++
 rtl/ahb_prior_aging.sv | 163 ++++++++++++++++
 tb/tb_ahb_prior_aging.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ahb_prior_aging_if.sv
// rtl/ahb_prior_aging_if.sv - bus bundle between requesters/arbiter and the priority aging block
interface ahb_prior_aging_if #(
  parameter int MASTER_NUM  = 2,
  parameter int PRIOR_LEVEL = 2,
  parameter int LVL_W       = ($clog2(PRIOR_LEVEL) < 1) ? 1 : $clog2(PRIOR_LEVEL)
);
  logic [MASTER_NUM-1:0]                  hreq;
  logic [MASTER_NUM-1:0]                  hgrant;
  logic                                   hwait;
  logic [MASTER_NUM-1:0][LVL_W-1:0]       base_prior;
  logic [MASTER_NUM-1:0][PRIOR_LEVEL-1:0] hprior;

  modport master (
    output hreq,
    output hgrant,
    output hwait,
    output base_prior,
    input  hprior
  );

  modport slave (
    input  hreq,
    input  hgrant,
    input  hwait,
    input  base_prior,
    output hprior
  );
endinterface

// File: rtl/ahb_prior_aging.sv
// rtl/ahb_prior_aging.sv - per-master priority aging for a dynamic-priority AHB arbiter; optional starvation flag under AHB_PRIOR_AGING_STARVE_EN
module ahb_prior_aging #(
  parameter int MASTER_NUM  = 2,
  parameter int PRIOR_LEVEL = 2,
  parameter int LVL_W       = ($clog2(PRIOR_LEVEL) < 1) ? 1 : $clog2(PRIOR_LEVEL),
  parameter int AGE_THRESH  = 8
) (
  input  logic                  hclk,
  input  logic                  hreset_n,
  ahb_prior_aging_if.slave      bus
`ifdef AHB_PRIOR_AGING_STARVE_EN
  ,
  output logic [MASTER_NUM-1:0] starve
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAITING = 2'd1,
    S_SERVED  = 2'd2
  } state_e;

  localparam logic [LVL_W-1:0] TOP_LVL  = LVL_W'(PRIOR_LEVEL - 1);
  localparam logic [7:0]       AGE_LAST = 8'(AGE_THRESH - 1);

  state_e           state_q [MASTER_NUM];
  state_e           state_d [MASTER_NUM];
  logic [LVL_W-1:0] lvl_q   [MASTER_NUM];
  logic [LVL_W-1:0] lvl_d   [MASTER_NUM];
  logic [7:0]       age_q   [MASTER_NUM];
  logic [7:0]       age_d   [MASTER_NUM];
  logic [LVL_W-1:0] eb      [MASTER_NUM];

  // Effective base level: out-of-range programming saturates to the top level
  always_comb begin
    for (int i = 0; i < MASTER_NUM; i++) begin
      eb[i] = (bus.base_prior[i] > TOP_LVL) ? TOP_LVL : bus.base_prior[i];
    end
  end

  // Per-master FSM next state, level and age counter
  always_comb begin
    for (int i = 0; i < MASTER_NUM; i++) begin
      state_d[i] = state_q[i];
      lvl_d[i]   = lvl_q[i];
      age_d[i]   = age_q[i];
      case (state_q[i])
        S_IDLE: begin
          lvl_d[i] = eb[i];
          age_d[i] = 8'd0;
          if (bus.hgrant[i]) begin
            state_d[i] = S_SERVED;
          end else if (bus.hreq[i]) begin
            state_d[i] = S_WAITING;
          end
        end
        S_WAITING: begin
          // Withdrawal and grant both take precedence over a boost in the same cycle
          if (!bus.hreq[i]) begin
            state_d[i] = S_IDLE;
            age_d[i]   = 8'd0;
          end else if (bus.hgrant[i]) begin
            state_d[i] = S_SERVED;
            age_d[i]   = 8'd0;
          end else if (age_q[i] == AGE_LAST) begin
            age_d[i] = 8'd0;
            lvl_d[i] = (lvl_q[i] == TOP_LVL) ? TOP_LVL : lvl_q[i] + LVL_W'(1);
          end else begin
            age_d[i] = age_q[i] + 8'd1;
          end
          // A raised base applies at once; a lowered base never demotes a waiting master
          if (lvl_d[i] < eb[i]) begin
            lvl_d[i] = eb[i];
          end
        end
        S_SERVED: begin
          // Level is frozen for the whole transaction, including slave wait states
          if (!bus.hgrant[i] && !bus.hwait) begin
            state_d[i] = S_IDLE;
          end
        end
        default: begin
          state_d[i] = S_IDLE;
        end
      endcase
    end
  end

  // State, level and age registers
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      for (int i = 0; i < MASTER_NUM; i++) begin
        state_q[i] <= S_IDLE;
        lvl_q[i]   <= '0;
        age_q[i]   <= 8'd0;
      end
    end else begin
      for (int i = 0; i < MASTER_NUM; i++) begin
        state_q[i] <= state_d[i];
        lvl_q[i]   <= lvl_d[i];
        age_q[i]   <= age_d[i];
      end
    end
  end

  // One-hot priority straight from the level register, no input-to-output path
  always_comb begin
    bus.hprior = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      bus.hprior[i] = PRIOR_LEVEL'(1) << lvl_q[i];
    end
  end

`ifdef AHB_PRIOR_AGING_STARVE_EN
  logic [7:0] starve_cnt_q [MASTER_NUM];
  logic [7:0] starve_cnt_d [MASTER_NUM];
  logic       starve_q     [MASTER_NUM];
  logic       starve_d     [MASTER_NUM];

  // Count stalled cycles spent already at the top level; sticky flag until served or idle
  always_comb begin
    for (int i = 0; i < MASTER_NUM; i++) begin
      starve_cnt_d[i] = starve_cnt_q[i];
      starve_d[i]     = starve_q[i];
      if (state_d[i] != S_WAITING) begin
        starve_cnt_d[i] = 8'd0;
        starve_d[i]     = 1'b0;
      end else if (state_q[i] == S_WAITING && lvl_q[i] == TOP_LVL) begin
        if (starve_cnt_q[i] != 8'hff) begin
          starve_cnt_d[i] = starve_cnt_q[i] + 8'd1;
        end
        if (starve_cnt_d[i] == 8'(AGE_THRESH)) begin
          starve_d[i] = 1'b1;
        end
      end
    end
  end

  // Starvation counter and flag registers
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      for (int i = 0; i < MASTER_NUM; i++) begin
        starve_cnt_q[i] <= 8'd0;
        starve_q[i]     <= 1'b0;
      end
    end else begin
      for (int i = 0; i < MASTER_NUM; i++) begin
        starve_cnt_q[i] <= starve_cnt_d[i];
        starve_q[i]     <= starve_d[i];
      end
    end
  end

  // Pack the per-master flags onto the output port
  always_comb begin
    starve = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      starve[i] = starve_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_ahb_prior_aging.sv
// tb/tb_ahb_prior_aging.sv - directed bench for ahb_prior_aging with 2-level and 4-level instances
module tb_ahb_prior_aging;

  logic hclk;
  logic hreset_n;
  int   tests;
  int   failed;

  ahb_prior_aging_if #(.MASTER_NUM(2), .PRIOR_LEVEL(2), .LVL_W(1)) b2 ();
  ahb_prior_aging_if #(.MASTER_NUM(2), .PRIOR_LEVEL(4), .LVL_W(2)) b4 ();

`ifdef AHB_PRIOR_AGING_STARVE_EN
  logic [1:0] starve2;
  logic [1:0] starve4;
`endif

  ahb_prior_aging #(.MASTER_NUM(2), .PRIOR_LEVEL(2), .LVL_W(1), .AGE_THRESH(8)) u_dut2 (
    .hclk     (hclk),
    .hreset_n (hreset_n),
    .bus      (b2)
`ifdef AHB_PRIOR_AGING_STARVE_EN
    ,
    .starve   (starve2)
`endif
  );

  ahb_prior_aging #(.MASTER_NUM(2), .PRIOR_LEVEL(4), .LVL_W(2), .AGE_THRESH(8)) u_dut4 (
    .hclk     (hclk),
    .hreset_n (hreset_n),
    .bus      (b4)
`ifdef AHB_PRIOR_AGING_STARVE_EN
    ,
    .starve   (starve4)
`endif
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge hclk);
      #1;
    end
  endtask

  initial begin
    tests         = 0;
    failed        = 0;
    hreset_n      = 1'b0;
    b2.hreq       = 2'b00;
    b2.hgrant     = 2'b00;
    b2.hwait      = 1'b0;
    b2.base_prior = {1'b1, 1'b0};
    b4.hreq       = 2'b00;
    b4.hgrant     = 2'b00;
    b4.hwait      = 1'b0;
    b4.base_prior = {2'd0, 2'd0};

    // reset values, then base loads one clock after release
    ticks(2);
    chk("reset_hprior2", 32'(b2.hprior), 32'h5);
    chk("reset_hprior4", 32'(b4.hprior), 32'h11);
`ifdef AHB_PRIOR_AGING_STARVE_EN
    chk("reset_starve", 32'(starve2), 32'h0);
`endif
    hreset_n = 1'b1;
    ticks(1);
    chk("release_load_eb", 32'(b2.hprior), 32'h9);

    // aging: master 0 stalled, boost every 8 cycles
    b2.hreq = 2'b01;
    b4.hreq = 2'b01;
    ticks(1);
    ticks(7);
    chk("age_no_boost_e7", 32'(b2.hprior), 32'h9);
    chk("age4_no_boost_e7", 32'(b4.hprior), 32'h11);
    ticks(1);
    chk("age_boost_e8", 32'(b2.hprior), 32'ha);
    chk("age4_boost_e8", 32'(b4.hprior), 32'h12);
`ifdef AHB_PRIOR_AGING_STARVE_EN
    ticks(7);
    chk("starve_e15", 32'(starve2), 32'h0);
    ticks(1);
    chk("starve_e16", 32'(starve2), 32'h1);
`else
    ticks(8);
`endif
    chk("age4_boost_e16", 32'(b4.hprior), 32'h14);
    chk("age_sat_e16", 32'(b2.hprior), 32'ha);
    ticks(8);
    chk("age4_boost_e24", 32'(b4.hprior), 32'h18);
    ticks(8);
    chk("age4_sat_e32", 32'(b4.hprior), 32'h18);

    // grant holds the boosted level through slave wait states
    b2.hgrant = 2'b01;
    b4.hgrant = 2'b01;
    ticks(1);
    chk("served_hold2", 32'(b2.hprior), 32'ha);
    chk("served_hold4", 32'(b4.hprior), 32'h18);
`ifdef AHB_PRIOR_AGING_STARVE_EN
    chk("starve_clr_grant", 32'(starve2), 32'h0);
`endif
    b2.hgrant = 2'b00;
    b4.hgrant = 2'b00;
    b2.hwait  = 1'b1;
    b4.hwait  = 1'b1;
    ticks(3);
    chk("wait_hold2", 32'(b2.hprior), 32'ha);
    chk("wait_hold4", 32'(b4.hprior), 32'h18);
    b2.hwait = 1'b0;
    b4.hwait = 1'b0;
    b2.hreq  = 2'b00;
    b4.hreq  = 2'b00;
    ticks(1);
    chk("idle_entry_hold", 32'(b2.hprior), 32'ha);
    ticks(1);
    chk("idle_reload2", 32'(b2.hprior), 32'h9);
    chk("idle_reload4", 32'(b4.hprior), 32'h11);

    // request drop at age 7: withdrawal wins, no boost
    b2.hreq = 2'b01;
    ticks(1);
    ticks(7);
    b2.hreq = 2'b00;
    ticks(1);
    chk("drop_at_thresh", 32'(b2.hprior), 32'h9);
    ticks(1);
    chk("drop_idle", 32'(b2.hprior), 32'h9);

    // grant at age 7: grant wins, no boost, FSM in SERVED
    b2.hreq = 2'b01;
    ticks(1);
    ticks(7);
    b2.hgrant = 2'b01;
    ticks(1);
    chk("grant_at_thresh", 32'(b2.hprior), 32'h9);
    b2.hgrant = 2'b00;
    b2.hwait  = 1'b1;
    ticks(10);
    chk("grant_served_state", 32'(b2.hprior), 32'h9);
    b2.hwait = 1'b0;
    b2.hreq  = 2'b00;
    ticks(2);
    chk("grant_done_idle", 32'(b2.hprior), 32'h9);

    // base change while idle
    b2.base_prior = {1'b1, 1'b1};
    ticks(1);
    chk("base_up_idle", 32'(b2.hprior), 32'ha);
    b2.base_prior = {1'b1, 1'b0};
    ticks(1);
    chk("base_down_idle", 32'(b2.hprior), 32'h9);

    // base change while waiting: raise applies, lowering never demotes
    b4.hreq = 2'b10;
    ticks(2);
    b4.base_prior = {2'd2, 2'd0};
    ticks(1);
    chk("wait_base_raise", 32'(b4.hprior), 32'h41);
    b4.base_prior = {2'd0, 2'd0};
    ticks(1);
    chk("wait_base_lower", 32'(b4.hprior), 32'h41);
    ticks(5);
    chk("wait_boost_from2", 32'(b4.hprior), 32'h81);
    b4.hreq = 2'b00;
    ticks(1);
    chk("wait_drop_hold", 32'(b4.hprior), 32'h81);
    ticks(1);
    chk("wait_drop_reload", 32'(b4.hprior), 32'h11);

    // asynchronous reset while boosted
    b2.hreq = 2'b01;
    ticks(1);
    ticks(8);
    chk("pre_reset_boost", 32'(b2.hprior), 32'ha);
    #2;
    hreset_n = 1'b0;
    #1;
    chk("async_reset2", 32'(b2.hprior), 32'h5);
    chk("async_reset4", 32'(b4.hprior), 32'h11);
`ifdef AHB_PRIOR_AGING_STARVE_EN
    chk("async_reset_starve", 32'(starve2), 32'h0);
`endif
    ticks(1);
    chk("reset_held", 32'(b2.hprior), 32'h5);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
